psum_requant: RTL and testbench

PSUM_REQUANT -- requirements
Module: psum_requant

---
 rtl/psum_requant_pkg.sv | 29 ++
 rtl/requant_unit.sv | 49 ++++
 rtl/psum_requant.sv | 138 +++++++++++++
 tb/tb_psum_requant.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_requant_pkg.sv
// Shared definitions for the partial-sum requantiser.
//   - Width macros for the PE array and everything downstream of it.
//   - FSM state enumeration used by psum_requant.
// No ports; import with psum_requant_pkg::*.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

`ifndef INPUT_SIZE
`define INPUT_SIZE 8
`endif

`ifndef PSUM_WIDTH
`define PSUM_WIDTH (2*`DATA_WIDTH+2)
`endif

`ifndef N_OUT
`define N_OUT (`INPUT_SIZE-2)
`endif

package psum_requant_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } rq_state_t;

endpackage

// File: rtl/requant_unit.sv
// Combinational requantiser: ReLU, round-half-up right shift, unsigned saturate.
// Ports:
//   i_psum  [PSUM_WIDTH]  signed two's-complement partial sum
//   o_data  [DATA_WIDTH]  unsigned requantised element

module requant_unit #(
    parameter int PSUM_WIDTH = 18,
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT      = 4
) (
    input  logic signed [PSUM_WIDTH-1:0] i_psum,
    output logic        [DATA_WIDTH-1:0] o_data
);

    // One guard bit so the rounding add can never overflow.
    localparam int RW = PSUM_WIDTH + 1;

    logic signed [RW-1:0] w_ext;
    logic signed [RW-1:0] w_shf;
    logic                 w_neg;
    logic                 w_sat;

    assign w_ext = {i_psum[PSUM_WIDTH-1], i_psum};
    assign w_neg = i_psum[PSUM_WIDTH-1];

    generate
        if (SHIFT == 0) begin : g_noshift
            assign w_shf = w_ext;
        end else begin : g_shift
            logic signed [RW-1:0] w_rnd;
            assign w_rnd = w_ext + RW'(2 ** (SHIFT - 1));
            assign w_shf = w_rnd >>> SHIFT;
        end
    endgenerate

    // Only non-negative values reach here, so any set bit above the
    // output width means the value exceeds the unsigned maximum.
    assign w_sat = |w_shf[RW-1:DATA_WIDTH];

    always_comb begin
        o_data = w_shf[DATA_WIDTH-1:0];
        if (w_neg) begin
            o_data = '0;
        end else if (w_sat) begin
            o_data = '1;
        end
    end

endmodule

// File: rtl/psum_requant.sv
// Captures a PE partial-sum vector on done_i and drains it one requantised
// element per transfer over a valid/ready stream.
// Ports:
//   clk_i        clock, rising edge
//   rst          synchronous active-high reset
//   psum_i       N_OUT signed partial sums, valid with done_i
//   done_i       PE completion strobe
//   out_valid_o  out_data_o valid
//   out_ready_i  downstream accept
//   out_data_o   requantised unsigned element
//   out_last_o   marks element N_OUT-1
//   busy_o       vector buffered
//   drop_o       sticky: a done_i arrived while busy and was discarded
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | bank empty, waiting for done_i
// ST_DRAIN | bank holds a vector, presenting bank[idx]

module psum_requant
    import psum_requant_pkg::*;
#(
    parameter  int DATA_WIDTH = `DATA_WIDTH,
    parameter  int INPUT_SIZE = `INPUT_SIZE,
    parameter  int SHIFT      = 4,
    localparam int PSUM_WIDTH = 2*DATA_WIDTH + 2,
    localparam int N_OUT      = INPUT_SIZE - 2
) (
    input  logic                         clk_i,
    input  logic                         rst,
    input  logic signed [PSUM_WIDTH-1:0] psum_i [N_OUT],
    input  logic                         done_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic        [DATA_WIDTH-1:0] out_data_o,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         drop_o
);

    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    rq_state_t                    r_state;
    rq_state_t                    w_next_state;
    logic        [IDX_W-1:0]      r_idx;
    logic signed [PSUM_WIDTH-1:0] r_bank [N_OUT];
    logic                         r_drop;

    logic                  w_drain;
    logic                  w_xfer;
    logic                  w_at_last;
    logic                  w_final_xfer;
    logic                  w_capture;
    logic                  w_drop_evt;
    logic [DATA_WIDTH-1:0] w_req;

    assign w_drain      = (r_state == ST_DRAIN);
    assign w_xfer       = w_drain && out_ready_i;
    assign w_at_last    = (r_idx == LAST_IDX);
    assign w_final_xfer = w_xfer && w_at_last;
    // A new vector is accepted when idle, or on the cycle the last element
    // leaves so back-to-back vectors stream without a bubble.
    assign w_capture    = done_i && (!w_drain || w_final_xfer);
    assign w_drop_evt   = done_i && w_drain && !w_final_xfer;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (done_i) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_final_xfer && !done_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_idx  <= '0;
            r_drop <= 1'b0;
        end else begin
            if (w_capture || w_final_xfer) begin
                r_idx <= '0;
            end else if (w_xfer) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_drop_evt) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Bank contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_bank <= psum_i;
        end
    end

    requant_unit #(
        .PSUM_WIDTH (PSUM_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT)
    ) u_requant (
        .i_psum (r_bank[r_idx]),
        .o_data (w_req)
    );

    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        busy_o      = 1'b0;
        drop_o      = r_drop;
        if (w_drain) begin
            out_valid_o = 1'b1;
            out_data_o  = w_req;
            out_last_o  = w_at_last;
            busy_o      = 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_requant.sv
module tb_psum_requant;

    localparam int DW = 8;
    localparam int N  = 6;
    localparam int PW = 2*DW + 2;
    localparam int SH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [PW-1:0] psum [N];
    logic                 done;
    logic                 valid;
    logic                 ready;
    logic [DW-1:0]        data;
    logic                 last;
    logic                 busy;
    logic                 drop;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the buffered vector plus a read position.
    bit     m_act;
    int     m_pos;
    bit     m_drop;
    longint m_vec [N];

    always #5 clk = ~clk;

    psum_requant #(
        .DATA_WIDTH (DW),
        .INPUT_SIZE (N + 2),
        .SHIFT      (SH)
    ) dut (
        .clk_i       (clk),
        .rst         (rst),
        .psum_i      (psum),
        .done_i      (done),
        .out_valid_o (valid),
        .out_ready_i (ready),
        .out_data_o  (data),
        .out_last_o  (last),
        .busy_o      (busy),
        .drop_o      (drop)
    );

    function automatic int rq(input longint p);
        longint r;
        if (p < 0) return 0;
        r = (p + (longint'(1) << (SH - 1))) / (longint'(1) << SH);
        if (r > (1 << DW) - 1) return (1 << DW) - 1;
        return int'(r);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        bit was;
        bit fin;
        if (rst) begin
            m_act  = 0;
            m_pos  = 0;
            m_drop = 0;
        end else begin
            was = m_act;
            fin = m_act && ready && (m_pos == N - 1);
            if (m_act && done && !fin) m_drop = 1;
            if (m_act && ready) begin
                m_pos++;
                if (m_pos == N) begin
                    m_act = 0;
                    m_pos = 0;
                end
            end
            if (done && (!was || fin)) begin
                for (int k = 0; k < N; k++) m_vec[k] = longint'(psum[k]);
                m_act = 1;
                m_pos = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("valid", int'(valid), int'(m_act));
        chk("busy",  int'(busy),  int'(m_act));
        chk("drop",  int'(drop),  int'(m_drop));
        chk("last",  int'(last),  int'(m_act && (m_pos == N - 1)));
        chk("data",  int'(data),  m_act ? rq(m_vec[m_pos]) : 0);
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_psum(input int a0, input int a1, input int a2,
                            input int a3, input int a4, input int a5);
        int a [N];
        a = '{a0, a1, a2, a3, a4, a5};
        for (int k = 0; k < N; k++) psum[k] = PW'(a[k]);
    endtask

    task automatic load_a();
        set_psum(100, -50, 5000, 24, 8, 7);
        done = 1'b1;
        cycle();
        done = 1'b0;
    endtask

    int ea [N];
    int eb [N];
    int es [N];

    initial begin
        ea = '{6, 0, 255, 2, 1, 0};
        eb = '{10, 20, 1, 0, 3, 4};
        es = '{255, 255, 254, 0, 1, 255};
        m_act = 0; m_pos = 0; m_drop = 0;
        for (int k = 0; k < N; k++) m_vec[k] = 0;

        rst   = 1'b1;
        done  = 1'b1;
        ready = 1'b1;
        set_psum(1, 2, 3, 4, 5, 6);
        cycle();
        done = 1'b0;
        cycle();
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_drop",  int'(drop),  0);
        chk("rst_data",  int'(data),  0);
        chk("rst_last",  int'(last),  0);
        rst = 1'b0;
        cycle();

        // Basic drain at full rate.
        load_a();
        for (int k = 0; k < N; k++) begin
            if (k > 0) cycle();
            chk("basic_data", int'(data), ea[k]);
            chk("basic_last", int'(last), (k == N - 1) ? 1 : 0);
        end
        cycle();
        chk("basic_idle", int'(valid), 0);

        // Backpressure at idx 2.
        load_a();
        cycle();
        cycle();
        chk("bp_idx2", int'(data), 255);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold", int'(data), 255);
            chk("bp_hold_last", int'(last), 0);
        end
        ready = 1'b1;
        for (int k = 3; k < N; k++) begin
            cycle();
            chk("bp_resume", int'(data), ea[k]);
        end
        cycle();

        // Back-to-back vectors.
        load_a();
        for (int k = 1; k < N; k++) cycle();
        chk("b2b_last_a", int'(last), 1);
        set_psum(160, 320, 16, -1, 48, 64);
        done = 1'b1;
        cycle();
        done = 1'b0;
        chk("b2b_first_b", int'(data), eb[0]);
        chk("b2b_busy", int'(busy), 1);
        for (int k = 1; k < N; k++) begin
            cycle();
            chk("b2b_data_b", int'(data), eb[k]);
            chk("b2b_busy", int'(busy), 1);
        end
        cycle();

        // Drop while draining.
        load_a();
        for (int k = 1; k < 4; k++) cycle();
        chk("drop_idx3", int'(data), ea[3]);
        set_psum(160, 320, 16, -1, 48, 64);
        done = 1'b1;
        cycle();
        done = 1'b0;
        chk("drop_set", int'(drop), 1);
        chk("drop_keep4", int'(data), ea[4]);
        cycle();
        chk("drop_keep5", int'(data), ea[5]);
        cycle();
        chk("drop_sticky", int'(drop), 1);

        // Reset mid-drain.
        load_a();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_busy",  int'(busy),  0);
        chk("mid_rst_drop",  int'(drop),  0);
        cycle();
        chk("mid_rst_quiet", int'(valid), 0);
        set_psum(160, 320, 16, -1, 48, 64);
        done = 1'b1;
        cycle();
        done = 1'b0;
        chk("mid_rst_restart", int'(data), eb[0]);
        for (int k = 1; k < N; k++) cycle();
        cycle();

        // Saturation and rounding boundaries.
        set_psum(4087, 4088, 4071, -1, 15, 131071);
        done = 1'b1;
        cycle();
        done = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k > 0) cycle();
            chk("sat_data", int'(data), es[k]);
        end
        cycle();

        // Randomised traffic.
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            done  = ($urandom_range(0, 6) == 0);
            ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 2))
                    0: psum[k] = PW'(int'($urandom_range(0, 8400)) - 4200);
                    1: psum[k] = PW'(int'($urandom_range(4000, 4200)));
                    default: psum[k] = PW'($urandom);
                endcase
            end
            cycle();
        end
        rst = 1'b0; done = 1'b0; ready = 1'b1;
        for (int c = 0; c < 10; c++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
